// File: rtl/mux_pkg.sv
// Shared defaults and the width helper for the round-robin N:1 mux and its FIFOs.
package mux_pkg;

  localparam int N_DEF     = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Smallest r with 2**r >= v; loop form keeps it usable in constant contexts.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered count; push/pop are ignored when full/empty.
module fifo_sync
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // Pointers wrap naturally because DEPTH is a power of two.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mux_rr_nx1.sv
// N input FIFOs merged onto one registered output stream by a round-robin arbiter.
module mux_rr_nx1
  import mux_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = clog2(N),
  localparam int AW   = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_full,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [CW-1:0]      out_chan,
  input  logic               out_ready,
  output logic [N-1:0]       ovf_err
);

  logic [N-1:0]     fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_rej;
  logic [WIDTH-1:0] fifo_dout [N];
  logic [AW:0]      fifo_cnt  [N];

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_chan_q, out_chan_d;
  logic [CW-1:0]    last_grant_q, last_grant_d;
  logic [N-1:0]     ovf_err_q, ovf_err_d;

  logic [CW-1:0]    grant;
  logic             found;
  logic             load;

  for (genvar i = 0; i < N; i++) begin : g_fifo
    // Rejection uses the registered count, so a same-cycle pop never frees a slot.
    assign fifo_rej[i]  = (fifo_cnt[i] == (AW+1)'(DEPTH));
    assign fifo_push[i] = in_valid[i] && !fifo_rej[i];
    assign fifo_pop[i]  = load && (grant == CW'(i));

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_L (reset_L),
      .push    (fifo_push[i]),
      .pop     (fifo_pop[i]),
      .din     (in_data[i*WIDTH +: WIDTH]),
      .dout    (fifo_dout[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i]),
      .count   (fifo_cnt[i])
    );
  end

  always_comb begin
    grant = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (int'(last_grant_q) + k) % N;
      if (!found && !fifo_empty[c]) begin
        found = 1'b1;
        grant = CW'(c);
      end
    end
  end

  assign load = (!out_valid_q || out_ready) && found;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    ovf_err_d    = ovf_err_q | (in_valid & fifo_rej);
    if (load) begin
      out_data_d   = fifo_dout[grant];
      out_chan_d   = grant;
      out_valid_d  = 1'b1;
      last_grant_d = grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      last_grant_q <= CW'(N - 1);
      ovf_err_q    <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign in_full   = fifo_full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed and random checks of mux_rr_nx1 against a queue-based behavioural model.
module tb_mux_rr_nx1;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_full;
  logic [7:0]   out_data;
  logic         out_valid;
  logic [1:0]   out_chan;
  logic         out_ready = 1'b0;
  logic [3:0]   ovf_err;

  int checks = 0;
  int errors = 0;

  // Model: one queue per channel, plus the visible output word and rr pointer.
  logic [7:0] mq [N][$];
  logic       m_ov;
  logic [7:0] m_od;
  int         m_oc;
  int         m_lg;
  logic [3:0] m_ovf;

  mux_rr_nx1 #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_full   (in_full),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ov  = 1'b0;
    m_od  = '0;
    m_oc  = 0;
    m_lg  = N - 1;
    m_ovf = '0;
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] full_exp;
    for (int i = 0; i < N; i++) full_exp[i] = (mq[i].size() == DEPTH);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_od));
    chk({tag, ".out_chan"},  32'(out_chan),  32'(m_oc));
    chk({tag, ".in_full"},   32'(in_full),   32'(full_exp));
    chk({tag, ".ovf_err"},   32'(ovf_err),   32'(m_ovf));
  endtask

  // Async reset applied between edges; outputs must clear before any clock.
  task automatic do_reset();
    #2;
    reset_L   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic r, input string tag);
    logic [3:0] full_pre;
    int         g;
    bit         any;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    for (int i = 0; i < N; i++) full_pre[i] = (mq[i].size() == DEPTH);
    any = 0;
    g   = 0;
    if (!m_ov || r) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_lg + k) % N;
        if (!any && mq[c].size() > 0) begin
          any = 1;
          g   = c;
        end
      end
    end
    @(posedge clk);
    #1;
    if (any) begin
      m_od = mq[g].pop_front();
      m_oc = g;
      m_ov = 1'b1;
      m_lg = g;
    end else if (m_ov && r) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (full_pre[i]) m_ovf[i] = 1'b1;
        else mq[i].push_back(d[i*8 +: 8]);
      end
    end
    in_valid = '0;
    compare_all(tag);
  endtask

  initial begin
    logic [7:0] exp_d;
    model_reset();
    do_reset();

    // Single word on ch2.
    step(4'b0100, 32'h00A5_0000, 1'b1, "single.push");
    step(4'b0000, 32'h0, 1'b1, "single.load");
    chk("single.valid", 32'(out_valid), 32'd1);
    chk("single.data",  32'(out_data),  32'hA5);
    chk("single.chan",  32'(out_chan),  32'd2);
    step(4'b0000, 32'h0, 1'b1, "single.drain");
    chk("single.drop", 32'(out_valid), 32'd0);

    // Fairness: two words per channel, continuous ready.
    do_reset();
    step(4'b1111, 32'h1312_1110, 1'b1, "fair.push1");
    step(4'b1111, 32'h2322_2120, 1'b1, "fair.push2");
    chk("fair.chan0", 32'(out_chan), 32'd0);
    chk("fair.data0", 32'(out_data), 32'h10);
    for (int i = 1; i < 8; i++) begin
      step(4'b0000, 32'h0, 1'b1, "fair.run");
      exp_d = ((i < 4) ? 8'h10 : 8'h20) + 8'(i % 4);
      chk("fair.valid", 32'(out_valid), 32'd1);
      chk("fair.chan",  32'(out_chan),  32'(i % 4));
      chk("fair.data",  32'(out_data),  32'(exp_d));
    end

    // Backpressure on ch0.
    do_reset();
    step(4'b0001, 32'h01, 1'b0, "bp.push1");
    step(4'b0001, 32'h02, 1'b0, "bp.push2");
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 32'h0, 1'b0, "bp.hold");
      chk("bp.hold_data",  32'(out_data),  32'h01);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
    end
    step(4'b0000, 32'h0, 1'b1, "bp.rel1");
    chk("bp.second", 32'(out_data), 32'h02);
    step(4'b0000, 32'h0, 1'b1, "bp.rel2");
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Overflow on ch1 behind a held ch0 word.
    do_reset();
    step(4'b0001, 32'h99, 1'b0, "ovf.hold");
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 32'(8'h30 + 8'(i)) << 8, 1'b0, "ovf.push");
      if (i == 3) chk("ovf.full_after4", 32'(in_full[1]), 32'd1);
    end
    chk("ovf.err", 32'(ovf_err[1]), 32'd1);
    chk("ovf.held", 32'(out_data), 32'h99);
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 32'h0, 1'b1, "ovf.drain");
      chk("ovf.drain_data", 32'(out_data), 32'(8'h30 + 8'(i)));
      chk("ovf.drain_chan", 32'(out_chan), 32'd1);
    end
    step(4'b0000, 32'h0, 1'b1, "ovf.end");
    chk("ovf.no34", 32'(out_valid), 32'd0);

    // Reset mid-operation.
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0110, 32'h0055_4400 + 32'(i), 1'b0, "mid.fill");
    do_reset();
    chk("mid.valid0", 32'(out_valid), 32'd0);
    step(4'b1000, 32'h7700_0000, 1'b1, "mid.push");
    step(4'b0000, 32'h0, 1'b1, "mid.load");
    chk("mid.chan", 32'(out_chan), 32'd3);
    chk("mid.data", 32'(out_data), 32'h77);

    // Random traffic with occasional backpressure.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      step(v, $urandom, ($urandom_range(0, 3) != 0), "rand");
    end
    for (int n = 0; n < 20; n++) step(4'b0000, 32'h0, 1'b1, "rand.drain");
    chk("rand.idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
